// File: rtl/lane_dispatch.sv
// Pops packets from a shared upstream FIFO and writes each to the lane FIFO
// selected by its 5-bit dest field. Optional broadcast: LANE_DISPATCH_BCAST_EN.
module lane_dispatch #(
  parameter int NUM_LANES = 20,
  parameter int PKT_W     = 36,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 src_empty,
  output logic                 src_read_req,
  input  logic                 src_read_gnt,
  input  logic [PKT_W-1:0]     src_packet,
  input  logic [NUM_LANES-1:0] lane_full,
  output logic [NUM_LANES-1:0] lane_write_req,
  input  logic [NUM_LANES-1:0] lane_write_gnt,
  output logic [PKT_W-1:0]     lane_packet,
  output logic                 busy,
  output logic [CNT_W-1:0]     sent_count,
  output logic [CNT_W-1:0]     drop_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITE
`ifdef LANE_DISPATCH_BCAST_EN
    , BWRITE
`endif
  } state_t;

  localparam logic [5:0] NUM_LANES_W = 6'(NUM_LANES);

  state_t                 state_q, state_d;
  logic                   src_read_req_q, src_read_req_d;
  logic [NUM_LANES-1:0]   lane_write_req_q, lane_write_req_d;
  logic [PKT_W-1:0]       lane_packet_q, lane_packet_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       sent_q, sent_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
`ifdef LANE_DISPATCH_BCAST_EN
  logic [NUM_LANES-1:0]   done_q, done_d;
  logic [NUM_LANES-1:0]   done_next;
`endif

  logic [4:0]             dest;
  logic [NUM_LANES-1:0]   dest_onehot;
  logic                   dest_valid;
  logic                   full_hit;
  logic                   gnt_hit;

  assign dest       = lane_packet_q[PKT_W-1 -: 5];
  assign dest_valid = ({1'b0, dest} < NUM_LANES_W);

  // One-hot decode keeps every lane lookup in range even for bad dest values.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_dec
    assign dest_onehot[gi] = (dest == 5'(gi));
  end

  assign full_hit = |(lane_full & dest_onehot);
  assign gnt_hit  = |(lane_write_gnt & lane_write_req_q);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d          = state_q;
    src_read_req_d   = src_read_req_q;
    lane_write_req_d = lane_write_req_q;
    lane_packet_d    = lane_packet_q;
    sent_d           = sent_q;
    drop_d           = drop_q;
`ifdef LANE_DISPATCH_BCAST_EN
    done_d           = done_q;
    done_next        = done_q | (lane_write_gnt & lane_write_req_q);
`endif
    unique case (state_q)
      IDLE: begin
        if (enable && !src_empty) begin
          state_d        = READ;
          src_read_req_d = 1'b1;
        end
      end
      READ: begin
        if (src_read_gnt) begin
          lane_packet_d  = src_packet;
          src_read_req_d = 1'b0;
          state_d        = CHECK;
        end
      end
      CHECK: begin
`ifdef LANE_DISPATCH_BCAST_EN
        if (dest == 5'h1F) begin
          if (!(|lane_full)) begin
            lane_write_req_d = '1;
            done_d           = '0;
            state_d          = BWRITE;
          end
        end else
`endif
        begin
          if (!dest_valid) begin
            drop_d  = sat_inc(drop_q);
            state_d = IDLE;
          end else if (!full_hit) begin
            lane_write_req_d = dest_onehot;
            state_d          = WRITE;
          end
        end
      end
      WRITE: begin
        if (gnt_hit) begin
          lane_write_req_d = '0;
          sent_d           = sat_inc(sent_q);
          state_d          = IDLE;
        end
      end
`ifdef LANE_DISPATCH_BCAST_EN
      BWRITE: begin
        // Each lane retires independently; the packet counts once when all are done.
        done_d           = done_next;
        lane_write_req_d = lane_write_req_q & ~lane_write_gnt;
        if (&done_next) begin
          lane_write_req_d = '0;
          sent_d           = sat_inc(sent_q);
          state_d          = IDLE;
        end
      end
`endif
      default: begin
        state_d          = IDLE;
        src_read_req_d   = 1'b0;
        lane_write_req_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      src_read_req_q   <= 1'b0;
      lane_write_req_q <= '0;
      lane_packet_q    <= '0;
      busy_q           <= 1'b0;
      sent_q           <= '0;
      drop_q           <= '0;
`ifdef LANE_DISPATCH_BCAST_EN
      done_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      src_read_req_q   <= src_read_req_d;
      lane_write_req_q <= lane_write_req_d;
      lane_packet_q    <= lane_packet_d;
      busy_q           <= busy_d;
      sent_q           <= sent_d;
      drop_q           <= drop_d;
`ifdef LANE_DISPATCH_BCAST_EN
      done_q           <= done_d;
`endif
    end
  end

  assign src_read_req   = src_read_req_q;
  assign lane_write_req = lane_write_req_q;
  assign lane_packet    = lane_packet_q;
  assign busy           = busy_q;
  assign sent_count     = sent_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_lane_dispatch.sv
// Directed bench for lane_dispatch; covers LANE_DISPATCH_BCAST_EN both ways.
module tb_lane_dispatch;
  localparam int NL = 20;
  localparam int PW = 36;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          src_empty;
  logic          src_read_req;
  logic          src_read_gnt;
  logic [PW-1:0] src_packet;
  logic [NL-1:0] lane_full;
  logic [NL-1:0] lane_write_req;
  logic [NL-1:0] lane_write_gnt;
  logic [PW-1:0] lane_packet;
  logic          busy;
  logic [CW-1:0] sent_count;
  logic [CW-1:0] drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lane_dispatch #(.NUM_LANES(NL), .PKT_W(PW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .src_empty      (src_empty),
    .src_read_req   (src_read_req),
    .src_read_gnt   (src_read_gnt),
    .src_packet     (src_packet),
    .lane_full      (lane_full),
    .lane_write_req (lane_write_req),
    .lane_write_gnt (lane_write_gnt),
    .lane_packet    (lane_packet),
    .busy           (busy),
    .sent_count     (sent_count),
    .drop_count     (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a pop of pkt with both grants given; leaves the FSM in CHECK.
  task automatic pop_to_check(input logic [PW-1:0] pkt, input string tag);
    src_packet = pkt;
    src_empty  = 1'b0;
    enable     = 1'b1;
    tick();
    chk({tag, "_rdreq"}, 64'(src_read_req), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    src_empty = 1'b1;
    tick();
    chk({tag, "_rdreq_drop"}, 64'(src_read_req), 64'd0);
    chk({tag, "_pkt"}, 64'(lane_packet), 64'(pkt));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; src_empty = 1'b1; src_read_gnt = 1'b0;
    src_packet = '0; lane_full = '0; lane_write_gnt = '0;
    #3;
    chk("rst_rdreq", 64'(src_read_req), 64'd0);
    chk("rst_wreq", 64'(lane_write_req), 64'd0);
    chk("rst_pkt", 64'(lane_packet), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sent", 64'(sent_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    tick();
    rst = 1'b0;

    // enable low keeps IDLE even with data available
    src_empty = 1'b0;
    tick(); tick();
    chk("dis_rdreq", 64'(src_read_req), 64'd0);
    chk("dis_busy", 64'(busy), 64'd0);
    src_empty = 1'b1;

    // single packet to lane 3, grants tied high
    src_read_gnt = 1'b1; lane_write_gnt = '1;
    pop_to_check(36'h1_8000_00AB, "single");
    tick();
    chk("single_wreq", 64'(lane_write_req), 64'h8);
    tick();
    chk("single_wreq_off", 64'(lane_write_req), 64'h0);
    chk("single_busy_off", 64'(busy), 64'd0);
    chk("single_sent", 64'(sent_count), 64'd1);
    chk("single_pkt_hold", 64'(lane_packet), 64'h1_8000_00AB);

    // dest 25 out of range
    pop_to_check({5'd25, 31'h0000_1234}, "oor");
    tick();
    chk("oor_wreq", 64'(lane_write_req), 64'h0);
    chk("oor_drop", 64'(drop_count), 64'd1);
    chk("oor_busy", 64'(busy), 64'd0);
    tick();
    chk("oor_single_pop", 64'(src_read_req), 64'd0);
    chk("oor_sent", 64'(sent_count), 64'd1);

    // lane 7 backpressure
    lane_full = 20'h00080;
    pop_to_check({5'd7, 31'h0000_0ABC}, "bp");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_wreq", 64'(lane_write_req), 64'h0);
    end
    chk("bp_busy", 64'(busy), 64'd1);
    lane_full = '0;
    tick();
    chk("bp_wreq", 64'(lane_write_req), 64'h80);
    tick();
    chk("bp_done", 64'(lane_write_req), 64'h0);
    chk("bp_sent", 64'(sent_count), 64'd2);

    // delayed grant on lane 0, with a stray grant on lane 5
    lane_write_gnt = 20'h00020;
    pop_to_check({5'd0, 31'h0000_55AA}, "dly");
    tick();
    chk("dly_wreq", 64'(lane_write_req), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dly_wreq_hold", 64'(lane_write_req), 64'h1);
      chk("dly_pkt_hold", 64'(lane_packet), 64'({5'd0, 31'h0000_55AA}));
    end
    lane_write_gnt = 20'h00021;
    tick();
    chk("dly_wreq_off", 64'(lane_write_req), 64'h0);
    chk("dly_sent", 64'(sent_count), 64'd3);
    chk("dly_busy", 64'(busy), 64'd0);

    // dest 31: broadcast or drop
    lane_write_gnt = '0;
    pop_to_check({5'h1F, 31'h0000_0F0F}, "bc");
`ifdef LANE_DISPATCH_BCAST_EN
    tick();
    chk("bc_wreq_all", 64'(lane_write_req), 64'hFFFFF);
    lane_write_gnt = 20'h0000F;
    tick();
    chk("bc_wreq_1", 64'(lane_write_req), 64'hFFFF0);
    lane_write_gnt = 20'hFFF00;
    tick();
    chk("bc_wreq_2", 64'(lane_write_req), 64'h000F0);
    chk("bc_busy_mid", 64'(busy), 64'd1);
    lane_write_gnt = 20'h000F0;
    tick();
    chk("bc_wreq_3", 64'(lane_write_req), 64'h0);
    chk("bc_sent", 64'(sent_count), 64'd4);
    chk("bc_drop", 64'(drop_count), 64'd1);
    chk("bc_busy", 64'(busy), 64'd0);
    lane_write_gnt = '0;
`else
    tick();
    chk("bc_wreq", 64'(lane_write_req), 64'h0);
    chk("bc_drop", 64'(drop_count), 64'd2);
    chk("bc_sent", 64'(sent_count), 64'd3);
    chk("bc_busy", 64'(busy), 64'd0);
`endif

    // async reset while lane 2 request is pending
    pop_to_check({5'd2, 31'h0000_0777}, "rw");
    tick();
    chk("rw_wreq", 64'(lane_write_req), 64'h4);
    #1 rst = 1'b1;
    #1;
    chk("rw_wreq_rst", 64'(lane_write_req), 64'h0);
    chk("rw_busy_rst", 64'(busy), 64'd0);
    chk("rw_sent_rst", 64'(sent_count), 64'd0);
    chk("rw_drop_rst", 64'(drop_count), 64'd0);
    chk("rw_pkt_rst", 64'(lane_packet), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rw_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lane_dispatch.md
Name: lane_dispatch

Overview:
- Scatter-side counterpart to the 20-lane merge path: pops 36-bit packets from one upstream FIFO and routes each to one of NUM_LANES per-lane FIFOs.
- Routing uses the destination field carried in the packet.
- Sits between the shared packet FIFO and the per-lane FIFOs that feed the clause-table / PE threads.
- Uses the same req/gnt/empty/full FIFO handshake as the existing fifo block, on both sides.

Parameters:
- NUM_LANES, 20, number of destination lanes (1..31).
- PKT_W, 36, packet width; dest field is bits [PKT_W-1:PKT_W-5].
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits new packet pops; in-flight packet always completes.
- src_empty  in  1  upstream FIFO empty.
- src_read_req  out  1  pop request to upstream FIFO.
- src_read_gnt  in  1  pop grant; src_packet valid in the same cycle.
- src_packet  in  PKT_W  upstream packet.
- lane_full  in  NUM_LANES  per-lane FIFO full; bit k = lane k.
- lane_write_req  out  NUM_LANES  per-lane write request; one-hot, except broadcast.
- lane_write_gnt  in  NUM_LANES  per-lane write grant.
- lane_packet  out  PKT_W  shared write data to all lanes, unchanged copy of the captured packet.
- busy  out  1  high in any state other than IDLE.
- sent_count  out  CNT_W  packets delivered; a broadcast counts once.
- drop_count  out  CNT_W  packets discarded because dest was out of range.

Behaviour:
- Reset (async, rst=1): state=IDLE; src_read_req=0; lane_write_req=0; lane_packet=0; busy=0; both counters=0. A packet in flight is lost. All outputs are registered.
- dest = captured_packet[PKT_W-1:PKT_W-5], an unsigned lane index; valid range 0..NUM_LANES-1.
- IDLE: if enable && !src_empty, go to READ with src_read_req=1 next cycle. Otherwise stay.
- READ: hold src_read_req=1 until src_read_gnt=1 is sampled. On that edge: capture src_packet into lane_packet, drop src_read_req, go to CHECK. src_empty is ignored while in READ.
- CHECK:
  - dest >= NUM_LANES (not broadcast): drop_count+1, go to IDLE.
  - lane_full[dest]=1: stay in CHECK; no request issued.
  - Otherwise: lane_write_req[dest]=1, go to WRITE.
- WRITE: hold lane_write_req[dest] and lane_packet stable until lane_write_gnt[dest]=1 is sampled. Then deassert the request next cycle, sent_count+1, go to IDLE.
- Grants on unrequested lanes are ignored. src_read_gnt outside READ is ignored.
- Minimum cost is 4 cycles per packet (IDLE, READ, CHECK, WRITE) when grants come back in the same cycle as the request.
- Back-to-back packets: IDLE re-evaluates src_empty the cycle after WRITE completes.
- Counters saturate at all-ones; they never wrap.
- enable deasserted mid-packet has no effect until the FSM is back in IDLE.
- lane_full rising during WRITE is ignored; the grant is authoritative.

Optional Feature:
- Macro: LANE_DISPATCH_BCAST_EN.
- Defined: dest == 5'h1F means broadcast.
  - CHECK waits until all lane_full bits are 0, then asserts lane_write_req on all lanes (BWRITE state).
  - Each lane's request drops individually on its grant; a done-mask tracks completion.
  - Leave BWRITE when the mask is all ones; sent_count+1.
- Undefined: dest 5'h1F is out of range like any other value ≥ NUM_LANES; it is dropped and drop_count increments.

Test Plan:
- Single packet: src_packet=36'h1_8000_00AB (dest=3), grants tied high → lane_write_req=0x0008 exactly one cycle, lane_packet=36'h1_8000_00AB, sent_count=1, busy low after 4 cycles.
- Out of range: dest=25, NUM_LANES=20 → no lane_write_req, drop_count=1, src_read_req popped once.
- Backpressure: dest=7 with lane_full[7]=1 held for 10 cycles → stays in CHECK with lane_write_req=0; 1 cycle after full clears, lane_write_req[7]=1.
- Delayed grant: lane_write_gnt[0] high 5 cycles after request → req and data stay stable for 5 cycles and drop the cycle after the grant; sent_count=1.
- Reset mid-WRITE: assert rst while lane_write_req[2]=1 → lane_write_req=0, busy=0, counters 0 immediately, without waiting for a clock edge.
- Broadcast (LANE_DISPATCH_BCAST_EN): dest=31, grants staggered per lane → lane_write_req=0xFFFFF, bits clear as each lane is granted, sent_count=1 at completion; with the macro undefined, drop_count=1 instead.
